// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// The sub field and its modport entries exist only when SUB_MODE_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SUB_MODE_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SUB_MODE_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice, LSB first, start/done handshake.
// Optional feature macro SUB_MODE_EN adds the sub input (a - b via ~b and carry 1).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             load;
  logic [WIDTH-1:0] a_sh, b_sh, sum_r;
  logic             carry, cout_r, busy_r, done_r;
  logic [CNT_W-1:0] cnt;
  logic             last, s_bit, c_bit;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

`ifdef SUB_MODE_EN
  assign b_load = bus.sub ? ~bus.b : bus.b;
  assign c_load = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_load = bus.b;
  assign c_load = bus.cin;
`endif

  assign last  = (cnt == CNT_W'(WIDTH - 1));
  assign s_bit = a_sh[0] ^ b_sh[0] ^ carry;
  assign c_bit = maj3(a_sh[0], b_sh[0], carry);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        state_nxt = RUN;
        load      = 1'b1;
      end
      RUN: if (last) state_nxt = DONE;
      DONE: begin
        // A start in the DONE cycle chains straight into the next operation.
        if (bus.start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_r <= (state_nxt == RUN);
      done_r <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (load) begin
      a_sh  <= bus.a;
      b_sh  <= b_load;
      carry <= c_load;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= c_bit;
      cnt   <= cnt + CNT_W'(1);
      // New result bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
      sum_r <= (sum_r >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
      if (last) cout_r <= c_bit;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8, 4 and 1 with a result scoreboard.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic [1:0] q1[$];

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(4)) if4 ();
  serial_adder_if #(.WIDTH(1)) if1 ();

  serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_adder #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  serial_adder #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // Drives one start on the WIDTH=8 instance and waits for done, recording what it saw.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                      output int bcnt, output int dat, output logic [8:0] res);
    @(negedge clk);
    if8.start = 1'b1; if8.a = a; if8.b = b; if8.cin = c;
`ifdef SUB_MODE_EN
    if8.sub = s;
`endif
    if (s) q8.push_back({1'b0, a} + {1'b0, ~b} + 9'd1);
    else   q8.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
    @(negedge clk);
    if8.start = 1'b0;
    bcnt = 0; dat = 0; res = 'x;
    for (int i = 1; i <= 40 && dat == 0; i++) begin
      if (if8.busy) bcnt++;
      if (if8.done) begin
        dat = i;
        res = {if8.cout, if8.sum};
      end
      if (dat == 0) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({if8.busy, if8.done, if8.cout, if8.sum} !== 11'd0) begin
      errors++; $display("FAIL reset_w8 got %h want 0", {if8.busy, if8.done, if8.cout, if8.sum});
    end
    checks++;
    if ({if4.busy, if4.done, if4.cout, if4.sum} !== 7'd0) begin
      errors++; $display("FAIL reset_w4 got %h want 0", {if4.busy, if4.done, if4.cout, if4.sum});
    end
    checks++;
    if ({if1.busy, if1.done, if1.cout, if1.sum} !== 4'd0) begin
      errors++; $display("FAIL reset_w1 got %h want 0", {if1.busy, if1.done, if1.cout, if1.sum});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add8();
    int bc, dt;
    logic [8:0] r, e;
    logic [7:0] ta[3] = '{8'h00, 8'hFF, 8'hA5};
    logic [7:0] tb[3] = '{8'h00, 8'h01, 8'h5A};
    logic       tc[3] = '{1'b0, 1'b0, 1'b1};
    logic [8:0] tw[3] = '{9'h000, 9'h100, 9'h100};
    for (int k = 0; k < 3; k++) begin
      run8(ta[k], tb[k], tc[k], 1'b0, bc, dt, r);
      e = q8.pop_front();
      checks++;
      if (r !== e || r !== tw[k]) begin
        errors++; $display("FAIL add8_%0d result got %h want %h", k, r, tw[k]);
      end
      checks++;
      if (dt != 9) begin errors++; $display("FAIL add8_%0d done_cycle got %0d want 9", k, dt); end
      checks++;
      if (bc != 8) begin errors++; $display("FAIL add8_%0d busy_cycles got %0d want 8", k, bc); end
      @(negedge clk);
      checks++;
      if (if8.done !== 1'b0 || if8.busy !== 1'b0) begin
        errors++; $display("FAIL add8_%0d after_done got busy=%b done=%b want 0 0", k, if8.busy, if8.done);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ndone = 0, gap = 0, waits = 0;
    logic [4:0] e;
    @(negedge clk);
    if4.a = 4'd0; if4.b = 4'd0; if4.cin = 1'b0; if4.start = 1'b1;
    q4.push_back(5'd0);
    while (ndone < 512 && waits < 5000) begin
      @(negedge clk);
      waits++; gap++;
      checks++;
      if (if4.busy && if4.done) begin errors++; $display("FAIL b2b_overlap got busy=1 done=1 want not both"); end
      if (if4.done) begin
        e = q4.pop_front();
        checks++;
        if ({if4.cout, if4.sum} !== e) begin
          errors++; $display("FAIL b2b_sum idx %0d got %h want %h", ndone, {if4.cout, if4.sum}, e);
        end
        checks++;
        if (gap != 5) begin errors++; $display("FAIL b2b_interval idx %0d got %0d want 5", ndone, gap); end
        gap = 0;
        ndone++;
        if (ndone < 512) begin
          if4.a = ndone[8:5]; if4.b = ndone[4:1]; if4.cin = ndone[0];
          q4.push_back({1'b0, if4.a} + {1'b0, if4.b} + {4'd0, if4.cin});
        end else begin
          if4.start = 1'b0;
        end
      end
    end
    checks++;
    if (ndone != 512) begin errors++; $display("FAIL b2b_count got %0d want 512", ndone); end
    repeat (8) @(negedge clk);
    checks++;
    if (if4.done !== 1'b0 || if4.busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got busy=%b done=%b want 0 0", if4.busy, if4.done);
    end
  endtask

  task automatic test_ignore_start();
    int nd = 0;
    logic [8:0] r = 'x, e;
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'h10; if8.b = 8'h20; if8.cin = 1'b0;
`ifdef SUB_MODE_EN
    if8.sub = 1'b0;
`endif
    q8.push_back(9'h030);
    @(negedge clk);
    if8.start = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 3) begin if8.start = 1'b1; if8.a = 8'hFF; if8.b = 8'hFF; end
      if (i == 4) if8.start = 1'b0;
      if (if8.done) begin nd++; r = {if8.cout, if8.sum}; end
      @(negedge clk);
    end
    e = q8.pop_front();
    checks++;
    if (nd != 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", nd); end
    checks++;
    if (r !== e) begin errors++; $display("FAIL ignore_result got %h want %h", r, e); end
  endtask

  task automatic test_reset_mid_run();
    int nd = 0, bc, dt;
    logic [8:0] r, e;
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'h12; if8.b = 8'h34; if8.cin = 1'b0;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if8.busy, if8.done, if8.cout, if8.sum} !== 11'd0) begin
      errors++; $display("FAIL midrst_clear got %h want 0", {if8.busy, if8.done, if8.cout, if8.sum});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if8.done || if8.busy) nd++;
    end
    checks++;
    if (nd != 0) begin errors++; $display("FAIL midrst_activity got %0d want 0", nd); end
    run8(8'h12, 8'h34, 1'b1, 1'b0, bc, dt, r);
    e = q8.pop_front();
    checks++;
    if (r !== e || dt != 9) begin
      errors++; $display("FAIL midrst_fresh got %h at %0d want %h at 9", r, dt, e);
    end
  endtask

`ifdef SUB_MODE_EN
  task automatic test_sub();
    int bc, dt;
    logic [8:0] r, e;
    run8(8'h05, 8'h07, 1'b0, 1'b1, bc, dt, r);
    e = q8.pop_front();
    checks++;
    if (r !== e || r !== 9'h0FE) begin errors++; $display("FAIL sub_5m7 got %h want 0fe", r); end
    run8(8'h07, 8'h05, 1'b0, 1'b1, bc, dt, r);
    e = q8.pop_front();
    checks++;
    if (r !== e || r !== 9'h102) begin errors++; $display("FAIL sub_7m5 got %h want 102", r); end
    if8.sub = 1'b0;
  endtask
`endif

  task automatic test_width1();
    int dt = 0;
    logic [1:0] r = 'x, e;
    @(negedge clk);
    if1.start = 1'b1; if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b1;
    q1.push_back(2'b11);
    @(negedge clk);
    if1.start = 1'b0;
    for (int i = 1; i <= 10 && dt == 0; i++) begin
      if (if1.done) begin dt = i; r = {if1.cout, if1.sum}; end
      if (dt == 0) @(negedge clk);
    end
    e = q1.pop_front();
    checks++;
    if (r !== e) begin errors++; $display("FAIL w1_result got %b want %b", r, e); end
    checks++;
    if (dt != 2) begin errors++; $display("FAIL w1_done_cycle got %0d want 2", dt); end
  endtask

  initial begin
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
`ifdef SUB_MODE_EN
    if8.sub = 1'b0; if4.sub = 1'b0; if1.sub = 1'b0;
`endif
    test_reset();
    test_add8();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_run();
`ifdef SUB_MODE_EN
    test_sub();
`endif
    test_width1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial, parametrised successor to the combinational one-bit full adder cell. It adds two WIDTH-bit operands one bit per clock, LSB first, using a single full-adder slice and a carry flip-flop. A start/done handshake lets datapath blocks trade latency (WIDTH cycles) for area. The block sits beside the existing adder cells as the multi-bit, clocked option.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A, captured on the accepted start.
- b  input  WIDTH  operand B, captured on the accepted start.
- cin  input  1  carry-in, captured on the accepted start.
- sub  input  1  subtract select; present only with SUB_MODE_EN.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when sum/cout become valid.
- sum  output  WIDTH  result; held until the next accepted start.
- cout  output  1  final carry-out; held with sum.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 loads the operand shift registers A←a and B←b, and sets carry←cin. It clears the bit counter and moves to RUN.
- RUN: each cycle computes s = A[0]^B[0]^carry and carry ← majority(A[0],B[0],carry).
  - A and B shift right.
  - s shifts into sum from the MSB side, so after WIDTH shifts sum holds the full result.
  - The counter increments. When the counter reaches WIDTH-1, the state moves to DONE and cout←carry.
- DONE: lasts one cycle with done=1.
  - start=1 in this cycle is accepted and the state goes straight to RUN (back-to-back operation).
  - Otherwise the state returns to IDLE.
- start during RUN is ignored; no queuing.
- sum and cout keep their last value in IDLE and DONE. During RUN they hold partial values and are not valid.
- The counter is $clog2(WIDTH)+1 bits, so WIDTH=1 is legal: the block spends one RUN cycle, then DONE.
- Arithmetic is modulo 2^WIDTH. cout is the true carry out of bit WIDTH-1.

## Timing
- Reset, asynchronous and taking effect immediately: state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, counter=0.
- Reset asserted mid-RUN aborts the operation. No done is produced and the outputs clear.
- Start accepted at rising edge k:
  - busy=1 from after edge k through edge k+WIDTH.
  - done=1 in the cycle after edge k+WIDTH.
  - Latency from start to done is WIDTH+1 cycles.
- busy and done are never high together.
- Back-to-back throughput: one result every WIDTH+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SUB_MODE_EN defined:
  - Adds the sub port.
  - With sub=1 at the accepted start, B is loaded as ~b and carry as 1, ignoring cin. The result is a-b mod 2^WIDTH.
  - cout=1 means no borrow (a≥b).
  - With sub=0, behaviour is identical to the undefined case.
- SUB_MODE_EN undefined: the sub port is absent and the block only adds.

## Test plan
- WIDTH=8: a=8'h00, b=8'h00, cin=0.
  - Required: done in the 9th cycle after start, sum=8'h00, cout=0, busy high for exactly 8 cycles.
- WIDTH=8: a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'hA5, b=8'h5A, cin=1 → sum=8'h00, cout=1.
- WIDTH=4, exhaustive sweep of all 512 (a,b,cin) combinations with back-to-back starts in the DONE cycles.
  - Required: each {cout,sum} equals a+b+cin.
  - Required: one done pulse per start.
- WIDTH=8: pulse start with a=8'h10, b=8'h20, then pulse start again 3 cycles later with a=8'hFF, b=8'hFF.
  - Required: the second start is ignored, and the single done gives sum=8'h30, cout=0.
- WIDTH=8: drop rst_n for 1 cycle 4 cycles into RUN.
  - Required: busy, done, sum and cout all read 0 immediately, and no done pulse follows.
  - Required: a fresh start after reset completes normally.
- SUB_MODE_EN, WIDTH=8:
  - sub=1, a=8'h05, b=8'h07 → sum=8'hFE, cout=0.
  - sub=1, a=8'h07, b=8'h05 → sum=8'h02, cout=1.
  - WIDTH=1, a=1, b=1, cin=1 (sub=0) → sum=1, cout=1 with done 2 cycles after start.
